// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared MDU operation codes and result type
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hiLo_t;

  function automatic logic isDivOp(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic isMultOp(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational product/quotient/remainder; MDU_DIVZERO_HOLD_EN selects divide-by-zero policy
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] curHi,
  input  logic [31:0] curLo,
  output hiLo_t       result
);

  logic        signedOp;
  logic        aNeg;
  logic        bNeg;
  logic [31:0] absA;
  logic [31:0] absB;
  logic [31:0] divisor;
  logic [31:0] uQuot;
  logic [31:0] uRem;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [63:0] aExt;
  logic [63:0] bExt;
  logic [63:0] prod;

  // Sign handling is done on magnitudes so the most-negative / -1 case wraps cleanly.
  always_comb begin
    signedOp = (op == MDU_MULT) || (op == MDU_DIV);
    aNeg     = signedOp & a[31];
    bNeg     = signedOp & b[31];
    absA     = aNeg ? (32'd0 - a) : a;
    absB     = bNeg ? (32'd0 - b) : b;
    divisor  = (absB == 32'd0) ? 32'd1 : absB;
    uQuot    = absA / divisor;
    uRem     = absA % divisor;
    quot     = (aNeg ^ bNeg) ? (32'd0 - uQuot) : uQuot;
    rem      = aNeg ? (32'd0 - uRem) : uRem;
    aExt     = signedOp ? {{32{a[31]}}, a} : {32'd0, a};
    bExt     = signedOp ? {{32{b[31]}}, b} : {32'd0, b};
    prod     = aExt * bExt;

    // Non-arithmetic codes pass the current HI/LO through unchanged.
    result.hi = curHi;
    result.lo = curLo;
    if (isMultOp(op)) begin
      result.hi = prod[63:32];
      result.lo = prod[31:0];
    end else if (isDivOp(op)) begin
      if (b == 32'd0) begin
`ifdef MDU_DIVZERO_HOLD_EN
        result.hi = curHi;
        result.lo = curLo;
`else
        result.hi = a;
        result.lo = 32'hFFFF_FFFF;
`endif
      end else begin
        result.hi = rem;
        result.lo = quot;
      end
    end
  end

endmodule

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle HI/LO multiply/divide unit (MDU_DIVZERO_HOLD_EN handled in mdu_arith)
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_type,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e      state;
  state_e      stateNext;
  logic [3:0]  cnt;
  logic [3:0]  cntNext;
  logic [31:0] hiNext;
  logic [31:0] loNext;
  logic [31:0] hiTmp;
  logic [31:0] loTmp;
  logic [31:0] hiTmpNext;
  logic [31:0] loTmpNext;
  logic        go;
  hiLo_t       arithRes;

  mdu_arith uArith (
    .op     (mdu_type),
    .a      (a),
    .b      (b),
    .curHi  (hi),
    .curLo  (lo),
    .result (arithRes)
  );

  // Result is computed at launch and held in hiTmp/loTmp; the BUSY phase only models latency.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    hiNext    = hi;
    loNext    = lo;
    hiTmpNext = hiTmp;
    loTmpNext = loTmp;
    go        = start & ~flush & (state == IDLE);

    case (state)
      IDLE: begin
        if (go) begin
          if (isMultOp(mdu_type) || isDivOp(mdu_type)) begin
            hiTmpNext = arithRes.hi;
            loTmpNext = arithRes.lo;
            cntNext   = isDivOp(mdu_type) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            stateNext = BUSY;
          end else if (mdu_type == MDU_MTHI) begin
            hiNext = a;
          end else if (mdu_type == MDU_MTLO) begin
            loNext = a;
          end
        end
      end
      BUSY: begin
        cntNext = cnt - 4'd1;
        if (cnt == 4'd1) begin
          hiNext    = hiTmp;
          loNext    = loTmp;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State, counter and HI/LO registers; reset clears everything including a pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      hiTmp <= 32'd0;
      loTmp <= 32'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      hi    <= hiNext;
      lo    <= loNext;
      hiTmp <= hiTmpNext;
      loTmp <= loTmpNext;
    end
  end

  // Read-out mux for mfhi/mflo feeding the EX result path.
  always_comb begin
    rd_data = 32'd0;
    if (mdu_type == MDU_MFHI)      rd_data = hi;
    else if (mdu_type == MDU_MFLO) rd_data = lo;
  end

  assign busy = (state == BUSY);

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - self-checking bench for mdu against an arithmetic reference model
module tb_mdu;
  import mdu_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_type;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mHi;
  logic [31:0] mLo;

  always #5 clk = ~clk;

  mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mdu_type (mdu_type),
    .flush    (flush),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo),
    .rd_data  (rd_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: architectural effect of one operation on {HI,LO}.
  task automatic model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, sp, sq, sr;
    longint unsigned up;
    int ix, iy;
    ix = x;
    iy = y;
    sx = ix;
    sy = iy;
    case (op)
      MDU_MULT: begin
        sp = sx * sy;
        mHi = sp[63:32];
        mLo = sp[31:0];
      end
      MDU_MULTU: begin
        up = longint'(x) * longint'(y);
        mHi = up[63:32];
        mLo = up[31:0];
      end
      MDU_DIV, MDU_DIVU: begin
        if (y == 0) begin
`ifndef MDU_DIVZERO_HOLD_EN
          mHi = x;
          mLo = 32'hFFFF_FFFF;
`endif
        end else if (op == MDU_DIV) begin
          sq = sx / sy;
          sr = sx % sy;
          mHi = sr[31:0];
          mLo = sq[31:0];
        end else begin
          mHi = x % y;
          mLo = x / y;
        end
      end
      MDU_MTHI: mHi = x;
      MDU_MTLO: mLo = x;
      default: ;
    endcase
  endtask

  // Issue one operation and check busy window and final HI/LO.
  task automatic runOp(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic flushInBusy);
    int n;
    logic [31:0] oldHi, oldLo;
    oldHi = mHi;
    oldLo = mLo;
    n = isDivOp(op) ? DIV_N : (isMultOp(op) ? MULT_N : 0);
    start = 1'b1; mdu_type = op; a = x; b = y; flush = 1'b0;
    tick();
    start = 1'b0; mdu_type = MDU_NONE; a = $urandom; b = $urandom;
    model(op, x, y);
    for (int k = 1; k <= n; k++) begin
      flush = flushInBusy;
      check($sformatf("busy_c%0d", k), {31'd0, busy}, 32'd1);
      if (k == n / 2) begin
        check("hold_hi", hi, oldHi);
        check("hold_lo", lo, oldLo);
      end
      tick();
    end
    flush = 1'b0;
    check("done_busy", {31'd0, busy}, 32'd0);
    check("done_hi", hi, mHi);
    check("done_lo", lo, mLo);
  endtask

  initial begin
    logic [3:0] ops [6];
    logic [31:0] x, y;
    ops = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO};
    reset = 1'b1; start = 1'b0; mdu_type = MDU_NONE; flush = 1'b0; a = '0; b = '0;
    mHi = '0; mLo = '0;
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_rd", rd_data, 32'd0);
    reset = 1'b0;
    tick();

    runOp(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("mult_hi_k", hi, 32'hFFFF_FFFF);
    check("mult_lo_k", lo, 32'hFFFF_FFFA);

    runOp(MDU_DIVU, 32'd100, 32'd7, 1'b0);
    check("divu_lo_k", lo, 32'd14);
    check("divu_hi_k", hi, 32'd2);

    runOp(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_lo_k", lo, 32'hFFFF_FFFD);
    check("div_hi_k", hi, 32'hFFFF_FFFF);

    runOp(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check("ovf_lo_k", lo, 32'h8000_0000);
    check("ovf_hi_k", hi, 32'd0);

    // Flushed MTLO must not write.
    start = 1'b1; mdu_type = MDU_MTLO; a = 32'h1234; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0; mdu_type = MDU_NONE;
    check("flush_lo", lo, 32'h8000_0000);
    check("flush_busy", {31'd0, busy}, 32'd0);

    runOp(MDU_MTLO, 32'h1234, 32'd0, 1'b0);
    runOp(MDU_MTHI, 32'hCAFE_F00D, 32'd0, 1'b0);
    mdu_type = MDU_MFLO; #1;
    check("mflo_rd", rd_data, 32'h1234);
    mdu_type = MDU_MFHI; #1;
    check("mfhi_rd", rd_data, 32'hCAFE_F00D);
    mdu_type = MDU_NONE; #1;
    check("none_rd", rd_data, 32'd0);

    // Divide by zero with HI=LO=5 preset.
    runOp(MDU_MTHI, 32'd5, 32'd0, 1'b0);
    runOp(MDU_MTLO, 32'd5, 32'd0, 1'b0);
    runOp(MDU_DIVU, 32'd77, 32'd0, 1'b0);
`ifdef MDU_DIVZERO_HOLD_EN
    check("dz_hi_k", hi, 32'd5);
    check("dz_lo_k", lo, 32'd5);
`else
    check("dz_hi_k", hi, 32'd77);
    check("dz_lo_k", lo, 32'hFFFF_FFFF);
`endif
    runOp(MDU_DIV, 32'hFFFF_FF00, 32'd0, 1'b0);

    // Reset in the third BUSY cycle of a MULT.
    start = 1'b1; mdu_type = MDU_MULT; a = 32'd1000; b = 32'd1000;
    tick();
    start = 1'b0; mdu_type = MDU_NONE;
    tick(); tick();
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mHi = '0; mLo = '0;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_hi", hi, 32'd0);
    check("mid_rst_lo", lo, 32'd0);
    for (int k = 0; k < 8; k++) tick();
    check("no_commit_hi", hi, 32'd0);
    check("no_commit_lo", lo, 32'd0);
    check("no_commit_busy", {31'd0, busy}, 32'd0);

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = $urandom_range(1, 15);
        2: x = 32'h8000_0000;
        default: ;
      endcase
      runOp(ops[$urandom_range(0, 5)], x, y, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
